// File: rtl/face_scan_scheduler.sv
// Raster-order window sequencer for the face-detection back end: issues one classifier
// request per 19x19 window, relays each score to the threshold stage and queues faces for the host.
module face_scan_scheduler #(
    parameter int IMG_W       = 81,
    parameter int IMG_H       = 61,
    parameter int WIN         = 19,
    parameter int STEP        = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int THR_TIMEOUT = 8
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iStart,
    output logic        oBusy,
    output logic        oDone,
    output logic        oCls_start,
    output logic [12:0] oCls_position,
    input  logic        iCls_done,
    input  logic [31:0] iCls_max_val,
    output logic        oThr_input_ready,
    output logic [12:0] oThr_position,
    output logic [31:0] oThr_max_val,
    output logic        oThr_finish,
    input  logic        iThr_output_ready,
    input  logic [12:0] iThr_position,
    input  logic        iThr_end,
    output logic        oDet_valid,
    output logic [12:0] oDet_position,
    input  logic        iDet_read,
    output logic        oDet_overflow,
    output logic        oErr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(THR_TIMEOUT + 1);
    localparam logic [13:0]      X_MAX        = 14'(IMG_W - WIN);
    localparam logic [13:0]      Y_MAX        = 14'(IMG_H - WIN);
    localparam logic [13:0]      STEP_W       = 14'(STEP);
    localparam logic [12:0]      ROW_STEP     = 13'(STEP * IMG_W);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(THR_TIMEOUT);
    localparam logic [PTR_W:0]   FIFO_FULL    = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CLS_REQ   = 4'd1,
        S_CLS_WAIT  = 4'd2,
        S_THR_ISSUE = 4'd3,
        S_THR_CHECK = 4'd4,
        S_THR_WAIT  = 4'd5,
        S_ADVANCE   = 4'd6,
        S_FLUSH     = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    state_t            state_q;
    logic [12:0]       x_q;
    logic [12:0]       y_q;
    logic [12:0]       row_base_q;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              cls_start_q;
    logic [12:0]       cls_position_q;
    logic              thr_input_ready_q;
    logic [12:0]       thr_position_q;
    logic [31:0]       thr_max_val_q;
    logic              thr_finish_q;
    logic              err_q;

    logic [13:0]       x_next_d;
    logic [13:0]       y_next_d;
    logic [12:0]       row_base_next_d;
    logic              x_fits_s;
    logic              y_done_s;

    logic [12:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q;
    logic [PTR_W:0]    rd_ptr_q;
    logic              overflow_q;
    logic [PTR_W:0]    fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              start_accept_s;
    logic              push_s;
    logic              pop_s;
    logic              push_ok_s;

    // Window stepping arithmetic; row stepping uses a running row base instead of y*IMG_W.
    always_comb begin
        x_next_d        = {1'b0, x_q} + STEP_W;
        y_next_d        = {1'b0, y_q} + STEP_W;
        row_base_next_d = row_base_q + ROW_STEP;
        x_fits_s        = (x_next_d <= X_MAX);
        y_done_s        = (y_next_d > Y_MAX);
    end

    assign start_accept_s = (state_q == S_IDLE) && iStart;

    // Scan FSM with registered handshake outputs.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q           <= S_IDLE;
            x_q               <= 13'd0;
            y_q               <= 13'd0;
            row_base_q        <= 13'd0;
            tmo_cnt_q         <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            cls_start_q       <= 1'b0;
            cls_position_q    <= 13'd0;
            thr_input_ready_q <= 1'b0;
            thr_position_q    <= 13'd0;
            thr_max_val_q     <= 32'd0;
            thr_finish_q      <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            cls_start_q       <= 1'b0;
            thr_input_ready_q <= 1'b0;
            thr_finish_q      <= 1'b0;
            done_q            <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (iStart) begin
                        x_q            <= 13'd0;
                        y_q            <= 13'd0;
                        row_base_q     <= 13'd0;
                        err_q          <= 1'b0;
                        busy_q         <= 1'b1;
                        cls_start_q    <= 1'b1;
                        cls_position_q <= 13'd0;
                        state_q        <= S_CLS_REQ;
                    end
                end
                S_CLS_REQ: begin
                    state_q <= S_CLS_WAIT;
                end
                S_CLS_WAIT: begin
                    if (iCls_done) begin
                        thr_max_val_q     <= iCls_max_val;
                        thr_position_q    <= cls_position_q;
                        thr_input_ready_q <= 1'b1;
                        state_q           <= S_THR_ISSUE;
                    end
                end
                S_THR_ISSUE: begin
                    state_q <= S_THR_CHECK;
                end
                // The end flag idles high, so it only means "no face" in this one cycle.
                S_THR_CHECK: begin
                    if (iThr_end) begin
                        state_q <= S_ADVANCE;
                    end else begin
                        tmo_cnt_q <= TIMEOUT_LOAD;
                        state_q   <= S_THR_WAIT;
                    end
                end
                S_THR_WAIT: begin
                    if (iThr_output_ready) begin
                        state_q <= S_ADVANCE;
                    end else if (tmo_cnt_q <= CNT_W'(1)) begin
                        tmo_cnt_q <= '0;
                        err_q     <= 1'b1;
                        state_q   <= S_ADVANCE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q - CNT_W'(1);
                    end
                end
                S_ADVANCE: begin
                    if (x_fits_s) begin
                        x_q            <= x_next_d[12:0];
                        cls_start_q    <= 1'b1;
                        cls_position_q <= row_base_q + x_next_d[12:0];
                        state_q        <= S_CLS_REQ;
                    end else begin
                        x_q        <= 13'd0;
                        y_q        <= y_next_d[12:0];
                        row_base_q <= row_base_next_d;
                        if (y_done_s) begin
                            thr_finish_q <= 1'b1;
                            state_q      <= S_FLUSH;
                        end else begin
                            cls_start_q    <= 1'b1;
                            cls_position_q <= row_base_next_d;
                            state_q        <= S_CLS_REQ;
                        end
                    end
                end
                S_FLUSH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_count_s = wr_ptr_q - rd_ptr_q;
    assign fifo_full_s  = (fifo_count_s == FIFO_FULL);
    assign fifo_empty_s = (fifo_count_s == '0);
    assign push_s       = (state_q == S_THR_WAIT) && iThr_output_ready;
    assign pop_s        = iDet_read && !fifo_empty_s;
    // A simultaneous pop frees the head slot, so a push into a full FIFO still fits.
    assign push_ok_s    = push_s && (!fifo_full_s || pop_s);

    // Detection FIFO pointers and sticky overflow flag.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
            end
            if (start_accept_s) begin
                overflow_q <= 1'b0;
            end else if (push_s && !push_ok_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Detection FIFO storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge iClk) begin
        if (push_ok_s && !iReset) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= iThr_position;
        end
    end

    assign oBusy            = busy_q;
    assign oDone            = done_q;
    assign oCls_start       = cls_start_q;
    assign oCls_position    = cls_position_q;
    assign oThr_input_ready = thr_input_ready_q;
    assign oThr_position    = thr_position_q;
    assign oThr_max_val     = thr_max_val_q;
    assign oThr_finish      = thr_finish_q;
    assign oDet_valid       = !fifo_empty_s;
    assign oDet_position    = fifo_empty_s ? 13'd0 : fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign oDet_overflow    = overflow_q;
    assign oErr             = err_q;

endmodule

// File: tb/tb_face_scan_scheduler.sv
// Directed bench for face_scan_scheduler on an 81x21 image (64 windows) with reactive
// classifier/threshold models; each task checks one scenario inline.
module tb_face_scan_scheduler;

    localparam int IMG_W = 81;
    localparam int IMG_H = 21;
    localparam int WIN   = 19;
    localparam int STEP  = 2;

    logic        iClk = 1'b0;
    logic        iReset = 1'b0;
    logic        iStart = 1'b0;
    logic        oBusy, oDone, oCls_start;
    logic [12:0] oCls_position;
    logic        iCls_done = 1'b0;
    logic [31:0] iCls_max_val = 32'd0;
    logic        oThr_input_ready;
    logic [12:0] oThr_position;
    logic [31:0] oThr_max_val;
    logic        oThr_finish;
    logic        iThr_output_ready = 1'b0;
    logic [12:0] iThr_position = 13'd0;
    logic        iThr_end = 1'b1;
    logic        oDet_valid;
    logic [12:0] oDet_position;
    logic        iDet_read = 1'b0;
    logic        oDet_overflow, oErr;

    int checks = 0;
    int failures = 0;

    // 0: always end, 1: face only at window 164, 2: never respond, 3: every window a face
    int thr_mode = 0;

    int cyc = 0;
    int cls_pos_q[$];
    int cls_cyc_q[$];
    int first_thr_cyc, err_cyc, det_cyc, finish_cnt, finish_cyc, done_cnt, done_cyc;
    bit thr_seen, err_seen, det_seen;

    face_scan_scheduler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .STEP(STEP),
        .FIFO_DEPTH(8), .THR_TIMEOUT(8)
    ) dut (
        .iClk(iClk), .iReset(iReset), .iStart(iStart), .oBusy(oBusy), .oDone(oDone),
        .oCls_start(oCls_start), .oCls_position(oCls_position),
        .iCls_done(iCls_done), .iCls_max_val(iCls_max_val),
        .oThr_input_ready(oThr_input_ready), .oThr_position(oThr_position),
        .oThr_max_val(oThr_max_val), .oThr_finish(oThr_finish),
        .iThr_output_ready(iThr_output_ready), .iThr_position(iThr_position),
        .iThr_end(iThr_end), .oDet_valid(oDet_valid), .oDet_position(oDet_position),
        .iDet_read(iDet_read), .oDet_overflow(oDet_overflow), .oErr(oErr)
    );

    initial forever #5 iClk = ~iClk;

    // Classifier: result two cycles after each start pulse, score tagged with the position.
    initial begin
        int cnt;
        cnt = -1;
        forever begin
            @(posedge iClk); #1;
            iCls_done = 1'b0;
            if (iReset) begin
                cnt = -1;
            end else if (cnt == 0) begin
                iCls_done    = 1'b1;
                iCls_max_val = 32'hA000_0000 | {19'd0, oCls_position};
                cnt = -1;
            end else if (cnt > 0) begin
                cnt--;
            end
            if (oCls_start) cnt = 1;
        end
    end

    // Threshold stage: end flag idles high, drops for the one cycle after a pulse if a face follows.
    initial begin
        int cnt;
        bit end_low;
        bit face;
        logic [12:0] pos;
        cnt = -1;
        end_low = 1'b0;
        pos = 13'd0;
        forever begin
            @(posedge iClk); #1;
            iThr_output_ready = 1'b0;
            iThr_end = !end_low;
            end_low = 1'b0;
            if (iReset) begin
                cnt = -1;
            end else if (cnt == 0) begin
                iThr_output_ready = 1'b1;
                iThr_position = pos;
                cnt = -1;
            end else if (cnt > 0) begin
                cnt--;
            end
            if (oThr_input_ready && !iReset) begin
                face = (thr_mode == 2) || (thr_mode == 3) ||
                       (thr_mode == 1 && oThr_position == 13'd164);
                end_low = face;
                if (thr_mode == 1 && face) begin
                    cnt = 2;
                    pos = 13'd165;
                end else if (thr_mode == 3) begin
                    cnt = 1;
                    pos = oThr_position;
                end
            end
        end
    end

    // Event recorder, sampled after the models so test tasks can clear it beforehand.
    initial forever begin
        @(posedge iClk); #2;
        cyc++;
        if (oCls_start) begin
            cls_pos_q.push_back(int'(oCls_position));
            cls_cyc_q.push_back(cyc);
        end
        if (oThr_input_ready && !thr_seen) begin thr_seen = 1'b1; first_thr_cyc = cyc; end
        if (oErr && !err_seen) begin err_seen = 1'b1; err_cyc = cyc; end
        if (oDet_valid && !det_seen) begin det_seen = 1'b1; det_cyc = cyc; end
        if (oThr_finish) begin finish_cnt++; finish_cyc = cyc; end
        if (oDone) begin done_cnt++; done_cyc = cyc; end
    end

    function automatic logic [78:0] all_outs();
        return {oBusy, oDone, oCls_start, oCls_position, oThr_input_ready, oThr_position,
                oThr_max_val, oThr_finish, oDet_valid, oDet_position, oDet_overflow, oErr};
    endfunction

    task automatic clear_mon();
        cls_pos_q.delete();
        cls_cyc_q.delete();
        thr_seen = 1'b0; err_seen = 1'b0; det_seen = 1'b0;
        finish_cnt = 0; done_cnt = 0;
        first_thr_cyc = 0; err_cyc = 0; det_cyc = 0; finish_cyc = 0; done_cyc = 0;
    endtask

    task automatic start_frame();
        @(posedge iClk); #1;
        clear_mon();
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output logic busy_at_done);
        ok = 1'b0;
        busy_at_done = 1'bx;
        for (int i = 0; i < budget; i++) begin
            @(posedge iClk); #1;
            if (oDone) begin
                ok = 1'b1;
                busy_at_done = oBusy;
                break;
            end
        end
        #2;
    endtask

    task automatic test_reset();
        iReset = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        iReset = 1'b0;
        checks++;
        if (all_outs() !== 79'd0) begin failures++; $display("FAIL reset_outputs got=%h want=0", all_outs()); end
        repeat (3) @(posedge iClk);
        #1;
        checks++;
        if (oBusy !== 1'b0 || oCls_start !== 1'b0) begin
            failures++; $display("FAIL idle_hold busy=%b cls_start=%b want 0 0", oBusy, oCls_start);
        end
    endtask

    task automatic test_no_face();
        int exp_q[$];
        bit ok;
        logic bd;
        thr_mode = 0;
        start_frame();
        checks++;
        if (oBusy !== 1'b1 || oCls_start !== 1'b1 || oCls_position !== 13'd0) begin
            failures++;
            $display("FAIL start_latency busy=%b cls_start=%b pos=%0d want 1 1 0", oBusy, oCls_start, oCls_position);
        end
        wait_done(2000, ok, bd);
        checks++;
        if (!ok) begin failures++; $display("FAIL noface_done timeout, no oDone"); end
        checks++;
        if (bd !== 1'b0) begin failures++; $display("FAIL busy_at_done got=%b want 0", bd); end
        for (int y = 0; y <= IMG_H - WIN; y += STEP)
            for (int x = 0; x <= IMG_W - WIN; x += STEP)
                exp_q.push_back(y * IMG_W + x);
        checks++;
        if (cls_pos_q.size() != 64 || exp_q.size() != 64) begin
            failures++; $display("FAIL noface_count got=%0d want=64", cls_pos_q.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (cls_pos_q[i] != exp_q[i]) begin
                    failures++; $display("FAIL cls_pos[%0d] got=%0d want=%0d", i, cls_pos_q[i], exp_q[i]);
                end
            end
            checks++;
            if (cls_cyc_q[1] - cls_cyc_q[0] != 6) begin
                failures++; $display("FAIL noface_gap got=%0d want=6", cls_cyc_q[1] - cls_cyc_q[0]);
            end
            checks++;
            if (first_thr_cyc - cls_cyc_q[0] != 3) begin
                failures++; $display("FAIL thr_latency got=%0d want=3", first_thr_cyc - cls_cyc_q[0]);
            end
        end
        checks++;
        if (finish_cnt != 1 || done_cyc - finish_cyc != 1) begin
            failures++; $display("FAIL finish_seq count=%0d gap=%0d want 1 1", finish_cnt, done_cyc - finish_cyc);
        end
        checks++;
        if (oThr_position !== 13'd224 || oThr_max_val !== 32'hA000_00E0) begin
            failures++; $display("FAIL thr_hold pos=%0d val=%h want 224 a00000e0", oThr_position, oThr_max_val);
        end
        checks++;
        if (oDet_valid !== 1'b0 || oErr !== 1'b0) begin
            failures++; $display("FAIL noface_flags valid=%b err=%b want 0 0", oDet_valid, oErr);
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        logic bd;
        thr_mode = 0;
        start_frame();
        repeat (20) @(posedge iClk);
        #1;
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        wait_done(2000, ok, bd);
        repeat (5) @(posedge iClk);
        #3;
        checks++;
        if (!ok || cls_pos_q.size() != 64 || done_cnt != 1 || oBusy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start ok=%0b starts=%0d dones=%0d busy=%b want 1 64 1 0", ok, cls_pos_q.size(), done_cnt, oBusy);
        end
    endtask

    task automatic test_face_164();
        bit ok;
        logic bd;
        thr_mode = 1;
        start_frame();
        wait_done(2000, ok, bd);
        checks++;
        if (!ok || cls_pos_q.size() != 64) begin
            failures++; $display("FAIL face_run done=%0b starts=%0d want 1 64", ok, cls_pos_q.size());
        end else begin
            checks++;
            if (cls_pos_q[33] != 164 || cls_cyc_q[34] - cls_cyc_q[33] != 8) begin
                failures++; $display("FAIL face_gap pos=%0d gap=%0d want 164 8", cls_pos_q[33], cls_cyc_q[34] - cls_cyc_q[33]);
            end
            checks++;
            if (!det_seen || det_cyc - cls_cyc_q[33] != 7) begin
                failures++; $display("FAIL det_latency seen=%0b lat=%0d want 1 7", det_seen, det_cyc - cls_cyc_q[33]);
            end
        end
        checks++;
        if (oDet_valid !== 1'b1 || oDet_position !== 13'd165 || oErr !== 1'b0) begin
            failures++; $display("FAIL face_entry valid=%b pos=%0d err=%b want 1 165 0", oDet_valid, oDet_position, oErr);
        end
        iDet_read = 1'b1;
        @(posedge iClk); #1;
        iDet_read = 1'b0;
        checks++;
        if (oDet_valid !== 1'b0 || oDet_overflow !== 1'b0) begin
            failures++; $display("FAIL face_pop valid=%b ovf=%b want 0 0", oDet_valid, oDet_overflow);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic bd;
        thr_mode = 2;
        start_frame();
        wait_done(3000, ok, bd);
        checks++;
        if (!ok) begin failures++; $display("FAIL timeout_done no oDone"); end
        checks++;
        if (!err_seen || !thr_seen || err_cyc - first_thr_cyc != 10) begin
            failures++; $display("FAIL err_latency seen=%0b lat=%0d want 1 10", err_seen, err_cyc - first_thr_cyc);
        end
        checks++;
        if (oErr !== 1'b1 || oDet_valid !== 1'b0 || finish_cnt != 1 || cls_pos_q.size() != 64) begin
            failures++;
            $display("FAIL timeout_end err=%b valid=%b fin=%0d starts=%0d want 1 0 1 64", oErr, oDet_valid, finish_cnt, cls_pos_q.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        bit found;
        logic bd;
        thr_mode = 3;
        start_frame();
        checks++;
        if (oErr !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want 0", oErr); end
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge iClk); #1;
            if (oThr_input_ready && oThr_position == 13'd16) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL ovf_find window 16 not reached"); end
        @(posedge iClk); #1;
        @(posedge iClk); #1;
        checks++;
        if (oDet_valid !== 1'b1 || oDet_position !== 13'd0) begin
            failures++; $display("FAIL ovf_full valid=%b head=%0d want 1 0", oDet_valid, oDet_position);
        end
        iDet_read = 1'b1;
        @(posedge iClk); #1;
        iDet_read = 1'b0;
        wait_done(2000, ok, bd);
        checks++;
        if (!ok || oDet_overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_flag done=%0b ovf=%b want 1 1", ok, oDet_overflow);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (oDet_valid !== 1'b1 || oDet_position !== 13'(2 * i + 2)) begin
                failures++; $display("FAIL ovf_pop[%0d] valid=%b pos=%0d want 1 %0d", i, oDet_valid, oDet_position, 2 * i + 2);
            end
            iDet_read = 1'b1;
            @(posedge iClk); #1;
            iDet_read = 1'b0;
        end
        checks++;
        if (oDet_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty valid=%b want 0", oDet_valid); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit found;
        logic bd;
        thr_mode = 0;
        start_frame();
        checks++;
        if (oDet_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want 0", oDet_overflow); end
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge iClk); #1;
            if (oCls_start && oCls_position == 13'd178) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL mid_find window 178 not reached"); end
        @(posedge iClk); #1;
        iReset = 1'b1;
        @(posedge iClk); #1;
        iReset = 1'b0;
        checks++;
        if (all_outs() !== 79'd0) begin failures++; $display("FAIL mid_reset got=%h want=0", all_outs()); end
        repeat (4) @(posedge iClk);
        #1;
        checks++;
        if (oBusy !== 1'b0 || oCls_start !== 1'b0) begin
            failures++; $display("FAIL mid_idle busy=%b cls_start=%b want 0 0", oBusy, oCls_start);
        end
        start_frame();
        checks++;
        if (oCls_start !== 1'b1 || oCls_position !== 13'd0) begin
            failures++; $display("FAIL restart cls_start=%b pos=%0d want 1 0", oCls_start, oCls_position);
        end
        wait_done(2000, ok, bd);
        checks++;
        if (!ok || cls_pos_q.size() != 64) begin
            failures++; $display("FAIL restart_run done=%0b starts=%0d want 1 64", ok, cls_pos_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_no_face();
        test_start_while_busy();
        test_face_164();
        test_timeout();
        test_overflow();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/face_scan_scheduler.md
# face_scan_scheduler

Frame-level sequencer for the face-detection back end. It walks the 19x19 detection window across the image in raster order and requests one classifier evaluation per window. Each classifier result is forwarded to the threshold stage with the handshake that stage expects, and confirmed face positions are collected into a small detection FIFO for the host. It sits between the frame-control logic, the window classifier and the threshold stage, and owns the threshold stage's finish/flush signal.

## Interface
- IMG_W, 81, image width in pixels; this is also the row pitch of position addresses.
- IMG_H, 61, image height in pixels; IMG_W*IMG_H must be ≤ 8192.
- WIN, 19, window edge length.
- STEP, 2, window stride in x and in y; must be ≥ 1.
- FIFO_DEPTH, 8, number of detection FIFO entries; must be a power of 2.
- THR_TIMEOUT, 8, maximum cycles to wait for a threshold-stage response.
- iClk  in  1  sole clock; all logic is on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iStart  in  1  one-cycle pulse that starts a frame scan; ignored while oBusy=1.
- oBusy  out  1  high from the cycle after an accepted iStart until oDone.
- oDone  out  1  one-cycle pulse at the end of the frame.
- oCls_start  out  1  one-cycle pulse requesting a classifier evaluation.
- oCls_position  out  13  window top-left address, y*IMG_W+x; held stable until iCls_done.
- iCls_done  in  1  one-cycle pulse: classifier result is valid.
- iCls_max_val  in  32  classifier score; sampled when iCls_done=1.
- oThr_input_ready  out  1  one-cycle pulse to the threshold stage.
- oThr_position  out  13  window address presented to the threshold stage.
- oThr_max_val  out  32  score presented to the threshold stage.
- oThr_finish  out  1  one-cycle flush pulse to the threshold stage at end of frame.
- iThr_output_ready  in  1  threshold stage reports a face.
- iThr_position  in  13  face position from the threshold stage; valid with iThr_output_ready.
- iThr_end  in  1  threshold stage reports "below threshold".
- oDet_valid  out  1  detection FIFO is not empty.
- oDet_position  out  13  head entry of the FIFO (first-word fall-through).
- iDet_read  in  1  pops the head entry when oDet_valid=1; ignored when the FIFO is empty.
- oDet_overflow  out  1  sticky: a detection was dropped because the FIFO was full.
- oErr  out  1  sticky: a threshold-stage response timed out.

## Operation
- States: IDLE, CLS_REQ, CLS_WAIT, THR_ISSUE, THR_CHECK, THR_WAIT, ADVANCE, FLUSH, DONE.
- IDLE: on iStart, clear x, y, row_base, oDet_overflow and oErr, then go to CLS_REQ. FIFO contents are kept.
- CLS_REQ: drive oCls_start=1 and oCls_position=row_base+x, then go to CLS_WAIT.
- CLS_WAIT: wait with no timeout. On iCls_done, latch iCls_max_val into oThr_max_val and the position into oThr_position, then go to THR_ISSUE.
- THR_ISSUE: drive oThr_input_ready=1 for exactly one cycle, then go to THR_CHECK.
- THR_CHECK is the cycle after the pulse, and iThr_end is sampled only here.
  - iThr_end=1: no face; go to ADVANCE.
  - iThr_end=0: go to THR_WAIT and load the timeout counter with THR_TIMEOUT.
- THR_WAIT:
  - On iThr_output_ready, push iThr_position to the FIFO and go to ADVANCE.
  - Otherwise decrement the counter. When it reaches 0, set oErr and go to ADVANCE with nothing pushed.
- Outside THR_CHECK, the value of iThr_end is ignored. The threshold stage holds its end flag high between requests.
- ADVANCE, with row stepping done by addition only (no multiplier):
  - If x+STEP ≤ IMG_W-WIN: x += STEP, then go to CLS_REQ.
  - Otherwise x=0, y += STEP, row_base += STEP*IMG_W.
  - If the new y > IMG_H-WIN, go to FLUSH; otherwise go to CLS_REQ.
- FLUSH: drive oThr_finish=1 for one cycle, then go to DONE.
- DONE: drive oDone=1 for one cycle, then go to IDLE.
- Detection FIFO:
  - A push when the FIFO is full drops the entry and sets oDet_overflow.
  - A pop and a push in the same cycle are both accepted, even when the FIFO is full.
  - oDet_overflow and oErr clear only on iReset or an accepted iStart.

## Timing
- Reset values (also the result of iReset mid-frame, applied in the next cycle): all outputs 0, state=IDLE, FIFO empty, x=y=row_base=0.
- iReset takes priority over every other input.
- An accepted iStart at cycle T produces oBusy=1 and oCls_start=1 at T+1.
- iCls_done at cycle C produces oThr_input_ready at C+1; THR_CHECK occurs at C+2.
- Window with no face: ADVANCE at C+3, next oCls_start at C+4.
- Window with a face, iThr_output_ready at cycle R: the entry appears at oDet_position with oDet_valid=1 at R+1; next oCls_start at R+2.
- oThr_position and oThr_max_val are held from THR_ISSUE until the next iCls_done.
- Last window: ADVANCE → FLUSH (oThr_finish) → DONE (oDone) in consecutive cycles; oBusy drops together with oDone.

## Test plan
- IMG_W=81, IMG_H=21, STEP=2, classifier always done 2 cycles after start, threshold always returns end → 64 oCls_start pulses with positions 0,2,…,62,162,…,224; one oThr_finish, then oDone; FIFO empty.
- Same configuration, threshold model reports a face only at window 164: it returns output_ready 3 cycles after the pulse with iThr_position=165 → exactly one FIFO entry, 165; oErr=0.
- Threshold model never responds after iThr_end=0 → oErr=1 exactly THR_TIMEOUT+2 cycles after oThr_input_ready; the scan continues to oDone.
- Every window is a face and iDet_read is held at 0 with FIFO_DEPTH=8 → first 8 positions retained, oDet_overflow=1; a read plus a push in the same cycle while full keeps the count at 8.
- iReset asserted in CLS_WAIT of window 40 → all outputs 0 next cycle; a new iStart restarts at position 0. iStart pulsed while oBusy=1 → no effect.
